// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a 4x4 output-stationary systolic array.
// Holds A (by row) and B (by column), clears the array accumulators,
// then streams diagonally skewed operands and pulses done after drain.
module systolic_seq_ctrl #(
  parameter int unsigned DATA_SIZE   = 8,
  parameter int unsigned FEED_CYCLES = 10
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_en,
  input  logic [2:0]             wr_addr,
  input  logic [4*DATA_SIZE-1:0] wr_data,
  input  logic                   start,
  output logic [4*DATA_SIZE-1:0] arr_a,
  output logic [4*DATA_SIZE-1:0] arr_b,
  output logic                   arr_acc_resetn,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {StIdle, StClear, StFeed, StDone} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  // a_q[i] is row i of A; b_q[j] is column j of B; byte k is element k.
  logic [4*DATA_SIZE-1:0] a_q [4];
  logic [4*DATA_SIZE-1:0] a_d [4];
  logic [4*DATA_SIZE-1:0] b_q [4];
  logic [4*DATA_SIZE-1:0] b_d [4];

  // State, counter and operand buffers; reset also wipes the buffers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Next-state: buffer writes only in idle, so they stay frozen for a run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        if (wr_en) begin
          if (wr_addr[2]) b_d[wr_addr[1:0]] = wr_data;
          else            a_d[wr_addr[1:0]] = wr_data;
        end
        if (start) state_d = StClear;
      end
      StClear: begin
        cnt_d   = '0;
        state_d = StFeed;
      end
      StFeed: begin
        if (cnt_q == 4'(FEED_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from registers only: byte i carries element t-i of its
  // row/column while 0 <= t-i <= 3, otherwise zero so the array drains.
  always_comb begin
    arr_a = '0;
    arr_b = '0;
    if (state_q == StFeed) begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (cnt_q == 4'(i + k)) begin
            arr_a[i*DATA_SIZE +: DATA_SIZE] = a_q[i][k*DATA_SIZE +: DATA_SIZE];
            arr_b[i*DATA_SIZE +: DATA_SIZE] = b_q[i][k*DATA_SIZE +: DATA_SIZE];
          end
        end
      end
    end
    arr_acc_resetn = (state_q != StClear);
    busy           = (state_q != StIdle);
    done           = (state_q == StDone);
  end

endmodule
